pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 18, giving the data width in bits; legal range is 1..48.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port s_valid, input, 1 bit: the upstream word on s_data is valid.
REQ-005 The block SHALL have port s_ready, output, 1 bit: the block can accept an upstream word this cycle.
REQ-006 The block SHALL have port s_data, input, WIDTH bits: the upstream data word.
REQ-007 The block SHALL have port m_valid, output, 1 bit: m_data holds a valid word.
REQ-008 The block SHALL have port m_ready, input, 1 bit: downstream accepts m_data this cycle.
REQ-009 The block SHALL have port m_data, output, WIDTH bits: the downstream data word.
REQ-010 The block SHALL have port count, output, 2 bits: number of words held (0..2).

Function
REQ-011 Storage SHALL be two WIDTH-bit registers: main (drives m_data) and skid, each with a valid flag.
REQ-012 States SHALL be EMPTY (count=0), ONE (main valid, skid empty, count=1) and FULL (both valid, count=2).
REQ-013 An upstream transfer SHALL occur when s_valid&&s_ready is high at a rising clk edge.
REQ-014 A downstream transfer SHALL occur when m_valid&&m_ready is high at a rising clk edge.
REQ-015 s_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, derived only from registered state, with no combinational path from m_ready or s_valid.
REQ-016 m_valid SHALL be 1 in ONE and FULL, and m_data SHALL equal main.
REQ-017 In EMPTY, an upstream transfer SHALL load main with s_data and move to ONE; otherwise the block SHALL remain in EMPTY.
REQ-018 In ONE, simultaneous upstream and downstream transfers SHALL load main with s_data and remain in ONE.
REQ-019 In ONE, an upstream transfer alone SHALL load skid with s_data and move to FULL, leaving main unchanged.
REQ-020 In ONE, a downstream transfer alone SHALL move to EMPTY.
REQ-021 In ONE, with no transfer, the block SHALL remain in ONE.
REQ-022 In FULL, a downstream transfer SHALL copy skid to main and move to ONE; otherwise the block SHALL hold.
REQ-023 In FULL, s_valid SHALL be ignored.
REQ-024 Latency SHALL be 1 cycle from an upstream transfer into EMPTY to m_valid=1 with that word on m_data.
REQ-025 Sustained throughput SHALL be one word per cycle when m_ready is held at 1.
REQ-026 Words SHALL be delivered in acceptance order with no loss or duplication.
REQ-027 m_data and count SHALL remain stable while m_valid=1 and m_ready=0.
REQ-028 Register contents while invalid SHALL NOT be observable as valid; data-register updates on invalid cycles are permitted but SHALL NOT alter m_data while m_valid=1.

Reset
REQ-029 Asserting rst SHALL immediately, without waiting for clk, force state EMPTY, main=0, skid=0, m_valid=0, count=0 and s_ready=1.
REQ-030 rst asserted mid-operation SHALL discard all held words.
REQ-031 After rst deasserts, the first rising clk edge SHALL operate normally and accept a word if s_valid=1.
REQ-032 No transfer SHALL occur on any clk edge while rst is high.

Verification
REQ-033 Basic pass-through: reset, then s_valid=1, s_data=0x00005, m_ready=1 for 1 cycle -> next cycle m_valid=1, m_data=0x00005, count=1; the following cycle m_valid=0.
REQ-034 Backpressure fill: m_ready=0, send 0x11 then 0x22 on consecutive cycles -> count=2, s_ready=0, m_data=0x11; a third word 0x33 is held off.
REQ-035 Drain order: from the REQ-034 state, m_ready=1, s_valid=0 -> m_data 0x11 then 0x22 on successive cycles, then m_valid=0 and count=0.
REQ-036 Streaming: 100 incrementing words with m_ready=1 -> 100 consecutive output cycles, in order, count never 2.
REQ-037 Random stall: random s_valid/m_ready for 10000 cycles -> scoreboard shows no loss, duplication or reordering, and m_data is stable during stalls.
REQ-038 Async reset: assert rst between clk edges while in FULL -> m_valid=0, count=0 and s_ready=1 before the next edge; queued words are never output.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer; s_ready comes only from registered state
module pipe_skid_reg #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t st, st_nxt;
  logic [WIDTH-1:0] main_q, skid_q, main_nxt, skid_nxt;
  logic up, dn;
  assign s_ready = st != FULL;
  assign m_valid = st != EMPTY;
  assign m_data  = main_q;
  assign count   = st;
  assign up      = s_valid && s_ready;
  assign dn      = m_valid && m_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st     <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      st     <= st_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  always_comb begin
    st_nxt   = st;
    main_nxt = main_q;
    skid_nxt = skid_q;
    case (st)
      EMPTY: if (up) begin
        st_nxt   = ONE;
        main_nxt = s_data;
      end
      ONE: begin
        st_nxt   = up && !dn ? FULL : !up && dn ? EMPTY : ONE;
        main_nxt = up && dn ? s_data : main_q;
        skid_nxt = up && !dn ? s_data : skid_q;
      end
      FULL: if (dn) begin
        st_nxt   = ONE;
        main_nxt = skid_q;
      end
      default: st_nxt = EMPTY;
    endcase
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed + random scoreboard bench for pipe_skid_reg
module tb_pipe_skid_reg;
  localparam int W = 18;
  logic clk = 0, rst = 1, s_valid = 0, m_ready = 0;
  logic s_ready, m_valid;
  logic [W-1:0] s_data = '0, m_data, held;
  logic [1:0] count;
  logic [W-1:0] q[$];
  logic stalled = 0;
  int asserts = 0, fails = 0, nout = 0;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: mid-cycle sample of the transfers that the coming rising edge will perform
  always @(negedge clk) begin
    if (rst) stalled = 0;
    else begin
      if (stalled) begin
        check("stall_valid", 48'(m_valid), 48'd1);
        check("stall_data", 48'(m_data), 48'(held));
      end
      if (m_valid && m_ready) begin
        nout++;
        if (q.size() == 0) begin
          asserts++;
          fails++;
          $display("FAIL sb_underflow: got %0h expected no output", m_data);
        end else check("sb_data", 48'(m_data), 48'(q.pop_front()));
      end
      if (s_valid && s_ready) q.push_back(s_data);
      stalled = m_valid && !m_ready;
      held = m_data;
    end
  end

  initial begin
    #1;
    check("rst_valid", 48'(m_valid), 48'd0);
    check("rst_count", 48'(count), 48'd0);
    check("rst_sready", 48'(s_ready), 48'd1);
    check("rst_data", 48'(m_data), 48'd0);
    tick();
    rst = 0;
    // basic pass-through
    s_valid = 1; s_data = 18'h00005; m_ready = 1;
    tick();
    s_valid = 0;
    check("pt_valid", 48'(m_valid), 48'd1);
    check("pt_data", 48'(m_data), 48'h5);
    check("pt_count", 48'(count), 48'd1);
    tick();
    check("pt_valid_after", 48'(m_valid), 48'd0);
    // backpressure fill
    m_ready = 0; s_valid = 1; s_data = 18'h11;
    tick();
    check("bp1_count", 48'(count), 48'd1);
    check("bp1_sready", 48'(s_ready), 48'd1);
    s_data = 18'h22;
    tick();
    check("bp2_count", 48'(count), 48'd2);
    check("bp2_sready", 48'(s_ready), 48'd0);
    check("bp2_data", 48'(m_data), 48'h11);
    s_data = 18'h33;
    tick();
    check("bp3_count", 48'(count), 48'd2);
    check("bp3_data", 48'(m_data), 48'h11);
    // drain order
    s_valid = 0; m_ready = 1;
    tick();
    check("dr1_data", 48'(m_data), 48'h22);
    check("dr1_count", 48'(count), 48'd1);
    tick();
    check("dr2_valid", 48'(m_valid), 48'd0);
    check("dr2_count", 48'(count), 48'd0);
    // streaming
    nout = 0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1; s_data = W'(18'h100 + i);
      tick();
      check("st_valid", 48'(m_valid), 48'd1);
      check("st_not_full", 48'(count == 2'd2), 48'd0);
    end
    s_valid = 0;
    tick();
    check("st_outputs", 48'(nout), 48'd100);
    check("st_sb_empty", 48'(q.size()), 48'd0);
    // random stall
    for (int i = 0; i < 10000; i++) begin
      s_valid = 1'($urandom); m_ready = 1'($urandom); s_data = W'($urandom);
      tick();
    end
    s_valid = 0; m_ready = 1;
    tick(); tick(); tick();
    check("rnd_count", 48'(count), 48'd0);
    check("rnd_sb_empty", 48'(q.size()), 48'd0);
    // async reset while FULL
    m_ready = 0; s_valid = 1; s_data = 18'h3AAAA;
    tick();
    s_data = 18'h15555;
    tick();
    s_valid = 0;
    check("ar_full", 48'(count), 48'd2);
    #1 rst = 1;
    #1;
    check("ar_valid", 48'(m_valid), 48'd0);
    check("ar_count", 48'(count), 48'd0);
    check("ar_sready", 48'(s_ready), 48'd1);
    check("ar_data", 48'(m_data), 48'd0);
    q.delete();
    s_valid = 1; s_data = 18'h0BEEF; m_ready = 1;
    tick();
    check("ar_no_xfer", 48'(count), 48'd0);
    rst = 0; s_data = 18'h0CAFE;
    tick();
    s_valid = 0;
    check("ar_first_count", 48'(count), 48'd1);
    check("ar_first_data", 48'(m_data), 48'h0CAFE);
    tick(); tick();
    check("ar_end_count", 48'(count), 48'd0);
    check("ar_sb_empty", 48'(q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
